// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data (load/store) share one
// memory port. Ties alternate between the requesters, and each access lasts MEM_LAT cycles.
//
// state  | meaning
// IDLE   | waiting for if_req / d_req, arbitration happens here
// ACCESS | memory port driven for MEM_LAT cycles
// DONE   | one-cycle rdy pulse to the winner

module mem_arb #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rdy,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rdy,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_data_q, last_data_d;
    logic        if_gnt_q, if_gnt_d;
    logic        if_rdy_q, if_rdy_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_gnt_q, d_gnt_d;
    logic        d_rdy_q, d_rdy_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        pick_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        if_gnt_d    = 1'b0;
        if_rdy_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_gnt_d     = 1'b0;
        d_rdy_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // On a tie the requester that was not served last wins.
        pick_data   = d_req && (!if_req || !last_data_q);

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d     = ACCESS;
                    cnt_d       = LAT_INIT;
                    last_data_d = pick_data;
                    if_gnt_d    = !pick_data;
                    d_gnt_d     = pick_data;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_data && d_we;
                    mem_addr_d  = pick_data ? d_addr : if_addr;
                    mem_wdata_d = (pick_data && d_we) ? d_wdata : 32'h0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = DONE;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 16'h0;
                    mem_wdata_d = 32'h0;
                    // The memory port mapping still holds this cycle, so mem_we_q tells load from store.
                    if (last_data_q) begin
                        d_rdy_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rdy_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_data_q <= 1'b0;
            if_gnt_q    <= 1'b0;
            if_rdy_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_gnt_q     <= 1'b0;
            d_rdy_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0;
            mem_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            if_gnt_q    <= if_gnt_d;
            if_rdy_q    <= if_rdy_d;
            if_rdata_q  <= if_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_rdy_q     <= d_rdy_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rdy    = if_rdy_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rdy     = d_rdy_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
